// File: rtl/fdct_pkg.sv
// Shared constants and FSM encoding for the 4x4 forward integer core transform.
package fdct_pkg;

    localparam int COEF_64   = 64;
    localparam int COEF_83   = 83;
    localparam int COEF_36   = 36;
    localparam int SHIFT_ROW = 1;
    localparam int SHIFT_COL = 8;
    localparam int MID_W     = 16;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_OUT  = 1'b1
    } state_e;

endpackage

// File: rtl/fdct_butterfly4.sv
// Combinational 4-point forward butterfly with round-half-up shift and signed saturation.
module fdct_butterfly4 import fdct_pkg::*; #(
    parameter int IN_W  = 9,
    parameter int SHIFT = 1,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic signed [IN_W-1:0]  c,
    input  logic signed [IN_W-1:0]  d,
    output logic signed [OUT_W-1:0] y0,
    output logic signed [OUT_W-1:0] y1,
    output logic signed [OUT_W-1:0] y2,
    output logic signed [OUT_W-1:0] y3
);

    // Ten guard bits cover the x64/x83 gain plus the two butterfly additions.
    localparam int W = IN_W + 10;
    localparam logic signed [W-1:0] K64   = W'(COEF_64);
    localparam logic signed [W-1:0] K83   = W'(COEF_83);
    localparam logic signed [W-1:0] K36   = W'(COEF_36);
    localparam logic signed [W-1:0] RND   = W'(2 ** (SHIFT - 1));
    localparam logic signed [W-1:0] MAX_V = W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [W-1:0] MIN_V = W'(-(2 ** (OUT_W - 1)));

    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [W-1:0] y);
        logic signed [W-1:0] r;
        r = (y + RND) >>> SHIFT;
        if (r > MAX_V) return MAX_V[OUT_W-1:0];
        else if (r < MIN_V) return MIN_V[OUT_W-1:0];
        else return r[OUT_W-1:0];
    endfunction

    logic signed [W-1:0] a_s, b_s, c_s, d_s, e0_s, o0_s, e1_s, o1_s;

    // Sign-extend, even/odd split, then weighted sums.
    always_comb begin
        a_s  = {{(W-IN_W){a[IN_W-1]}}, a};
        b_s  = {{(W-IN_W){b[IN_W-1]}}, b};
        c_s  = {{(W-IN_W){c[IN_W-1]}}, c};
        d_s  = {{(W-IN_W){d[IN_W-1]}}, d};
        e0_s = a_s + d_s;
        o0_s = a_s - d_s;
        e1_s = b_s + c_s;
        o1_s = b_s - c_s;
        y0   = round_sat(K64 * (e0_s + e1_s));
        y2   = round_sat(K64 * (e0_s - e1_s));
        y1   = round_sat(K83 * o0_s + K36 * o1_s);
        y3   = round_sat(K36 * o0_s - K83 * o1_s);
    end

endmodule

// File: rtl/fdct_4x4.sv
// 4x4 forward core transform: row butterfly into a transpose buffer, column butterfly to
// registered outputs. Define FDCT_CBF_EN to add the coded-block flag output.
module fdct_4x4 import fdct_pkg::*; #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  d_in_1,
    input  logic signed [IN_W-1:0]  d_in_2,
    input  logic signed [IN_W-1:0]  d_in_3,
    input  logic signed [IN_W-1:0]  d_in_4,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic signed [OUT_W-1:0] d_out_1,
    output logic signed [OUT_W-1:0] d_out_2,
    output logic signed [OUT_W-1:0] d_out_3,
    output logic signed [OUT_W-1:0] d_out_4
`ifdef FDCT_CBF_EN
    ,
    output logic                    cbf
`endif
);

    state_e                    state_q, state_d;
    logic [1:0]                row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d, col_sel_s;
    logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                      in_acc_s, out_acc_s, col_load_s;
    logic signed [MID_W-1:0]   tbuf_q [4][4];
    logic signed [MID_W-1:0]   tbuf_d [4][4];
    logic signed [MID_W-1:0]   row_y_s [4];
    logic signed [MID_W-1:0]   col_in_s [4];
    logic signed [OUT_W-1:0]   col_y_s [4];
    logic signed [OUT_W-1:0]   dout_q [4];
    logic signed [OUT_W-1:0]   dout_d [4];
`ifdef FDCT_CBF_EN
    logic                      cbf_q, cbf_d;
    logic                      col_nz_s;
`endif

    fdct_butterfly4 #(.IN_W(IN_W), .SHIFT(SHIFT_ROW), .OUT_W(MID_W)) u_row (
        .a (d_in_1), .b (d_in_2), .c (d_in_3), .d (d_in_4),
        .y0(row_y_s[0]), .y1(row_y_s[1]), .y2(row_y_s[2]), .y3(row_y_s[3])
    );

    fdct_butterfly4 #(.IN_W(MID_W), .SHIFT(SHIFT_COL), .OUT_W(OUT_W)) u_col (
        .a (col_in_s[0]), .b (col_in_s[1]), .c (col_in_s[2]), .d (col_in_s[3]),
        .y0(col_y_s[0]), .y1(col_y_s[1]), .y2(col_y_s[2]), .y3(col_y_s[3])
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (in_valid && (row_cnt_q == 2'd3)) state_d = ST_OUT;  else state_d = ST_LOAD;
            ST_OUT:  if (out_ready && (col_cnt_q == 2'd3)) state_d = ST_LOAD; else state_d = ST_OUT;
            default: state_d = ST_LOAD;
        endcase
    end

    // FSM outputs and handshake decode.
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        in_acc_s  = in_valid && (state_q == ST_LOAD);
        out_acc_s = out_ready && (state_q == ST_OUT);
    end

    // Column source; row 3 of column 0 is forwarded straight from the row stage.
    always_comb begin
        col_sel_s = in_acc_s ? 2'd0 : (col_cnt_q + 2'd1);
        for (int r = 0; r < 3; r++) col_in_s[r] = tbuf_q[r][col_sel_s];
        if (in_acc_s) col_in_s[3] = row_y_s[0];
        else          col_in_s[3] = tbuf_q[3][col_sel_s];
    end

    // Buffer writes, counters and output-register next values.
    always_comb begin
        tbuf_d      = tbuf_q;
        dout_d      = dout_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        col_load_s  = 1'b0;
        if (in_acc_s) begin
            for (int j = 0; j < 4; j++) tbuf_d[row_cnt_q][j] = row_y_s[j];
            row_cnt_d = row_cnt_q + 2'd1;
            if (row_cnt_q == 2'd3) begin
                col_cnt_d   = 2'd0;
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                col_load_s  = 1'b1;
            end else begin
                col_load_s  = 1'b0;
            end
        end else if (out_acc_s) begin
            if (col_cnt_q == 2'd3) begin
                row_cnt_d   = 2'd0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                col_cnt_d   = col_cnt_q + 2'd1;
                out_last_d  = (col_cnt_q == 2'd2);
                col_load_s  = 1'b1;
            end
        end else begin
            col_load_s = 1'b0;
        end
        if (col_load_s) dout_d = col_y_s;
        else            dout_d = dout_q;
    end

    // Datapath, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_q   <= 2'd0;
            col_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                dout_q[r] <= {OUT_W{1'b0}};
                for (int k = 0; k < 4; k++) tbuf_q[r][k] <= {MID_W{1'b0}};
            end
        end else begin
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            dout_q      <= dout_d;
            tbuf_q      <= tbuf_d;
        end
    end

`ifdef FDCT_CBF_EN
    // Coded-block flag: restarts with column 0, accumulates over later columns.
    always_comb begin
        col_nz_s = (col_y_s[0] != {OUT_W{1'b0}}) || (col_y_s[1] != {OUT_W{1'b0}}) ||
                   (col_y_s[2] != {OUT_W{1'b0}}) || (col_y_s[3] != {OUT_W{1'b0}});
        if (col_load_s && in_acc_s) cbf_d = col_nz_s;
        else if (col_load_s)        cbf_d = cbf_q | col_nz_s;
        else                        cbf_d = cbf_q;
    end

    // Coded-block flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cbf_q <= 1'b0;
        else        cbf_q <= cbf_d;
    end

    assign cbf = cbf_q;
`endif

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign d_out_1   = dout_q[0];
    assign d_out_2   = dout_q[1];
    assign d_out_3   = dout_q[2];
    assign d_out_4   = dout_q[3];

endmodule

// File: tb/tb_fdct_4x4.sv
// Self-checking bench for fdct_4x4: directed and random blocks against a matrix reference model.
module tb_fdct_4x4;

    localparam int IN_W  = 9;
    localparam int OUT_W = 16;
    localparam int M [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                                '{64, -64, -64, 64}, '{36, -83, 83, -36}};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_last;
    logic signed [IN_W-1:0]  d_in_1 = '0, d_in_2 = '0, d_in_3 = '0, d_in_4 = '0;
    logic signed [OUT_W-1:0] d_out_1, d_out_2, d_out_3, d_out_4;
`ifdef FDCT_CBF_EN
    logic cbf;
`endif

    int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
    int x_blk [4][4];
    int c_exp [4][4];
    int t0, t1;

    fdct_4x4 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4)
`ifdef FDCT_CBF_EN
        , .cbf(cbf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd_sat(input longint y, input int s, input int w);
        longint r, hi, lo;
        r  = (y + (longint'(1) << (s - 1))) >>> s;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) return int'(hi);
        if (r < lo) return int'(lo);
        return int'(r);
    endfunction

    // Y = M * X^T applied to rows, then M applied down each column.
    function automatic void model();
        int rr [4][4];
        longint acc;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc += longint'(M[i][j]) * x_blk[r][j];
                rr[r][i] = rnd_sat(acc, 1, 16);
            end
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                acc = 0;
                for (int r = 0; r < 4; r++) acc += longint'(M[i][r]) * rr[r][k];
                c_exp[i][k] = rnd_sat(acc, 8, OUT_W);
            end
    endfunction

    function automatic void fill_const(input int v);
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) x_blk[r][j] = v;
    endfunction

    function automatic void fill_rand();
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++)
            x_blk[r][j] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 511)) - 256;
    endfunction

    task automatic send_rows(input int nrows, input bit gaps, output int t_first);
        int guard;
        t_first = -1;
        for (int r = 0; r < nrows; r++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                d_in_1 = IN_W'($urandom); d_in_2 = IN_W'($urandom);
                d_in_3 = IN_W'($urandom); d_in_4 = IN_W'($urandom);
                @(negedge clk);
            end
            guard = 0;
            while (!in_ready && guard < 32) begin @(negedge clk); guard++; end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (r == 0) t_first = cyc;
            in_valid = 1'b1;
            d_in_1 = IN_W'(x_blk[r][0]); d_in_2 = IN_W'(x_blk[r][1]);
            d_in_3 = IN_W'(x_blk[r][2]); d_in_4 = IN_W'(x_blk[r][3]);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_col(input string tag, input int k);
        chk($sformatf("%s c%0d d1", tag, k), d_out_1, c_exp[0][k]);
        chk($sformatf("%s c%0d d2", tag, k), d_out_2, c_exp[1][k]);
        chk($sformatf("%s c%0d d3", tag, k), d_out_3, c_exp[2][k]);
        chk($sformatf("%s c%0d d4", tag, k), d_out_4, c_exp[3][k]);
    endtask

    task automatic recv_block(input string tag, input bit toggle);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int step = 0;
        int guard;
        bit nz = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) if (c_exp[i][k] != 0) nz = 1'b1;
            out_ready = toggle ? pat[step % 4] : 1'b1;
            guard = 0;
            while (!out_ready && guard < 8) begin
                chk($sformatf("%s hold c%0d valid", tag, k), out_valid, 1);
                chk($sformatf("%s hold c%0d in_ready", tag, k), in_ready, 0);
                chk_col({tag, " hold"}, k);
                @(negedge clk);
                step++; guard++;
                out_ready = toggle ? pat[step % 4] : 1'b1;
            end
            chk($sformatf("%s c%0d valid", tag, k), out_valid, 1);
            chk($sformatf("%s c%0d last", tag, k), out_last, (k == 3) ? 1 : 0);
            chk($sformatf("%s c%0d in_ready", tag, k), in_ready, 0);
            chk_col(tag, k);
`ifdef FDCT_CBF_EN
            chk($sformatf("%s c%0d cbf", tag, k), cbf, nz);
`endif
            @(negedge clk);
            step++;
        end
        out_ready = 1'b0;
        chk({tag, " done valid"}, out_valid, 0);
        chk({tag, " done in_ready"}, in_ready, 1);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst d1", d_out_1, 0);
        chk("rst d4", d_out_4, 0);
`ifdef FDCT_CBF_EN
        chk("rst cbf", cbf, 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // All-zero blocks back to back; period must be 8 cycles.
        fill_const(0); model();
        send_rows(4, 1'b0, t0); recv_block("zero0", 1'b0);
        send_rows(4, 1'b0, t1); recv_block("zero1", 1'b0);
        chk("period", t1 - t0, 8);

        fill_const(1);    model(); send_rows(4, 1'b0, t0); recv_block("ones", 1'b0);
        fill_const(255);  model(); send_rows(4, 1'b0, t0); recv_block("p255", 1'b0);
        fill_const(-256); model(); send_rows(4, 1'b0, t0); recv_block("m256", 1'b0);

        // Impulse with input gaps and out_ready pattern 1-0-0-1.
        fill_const(0); x_blk[0][0] = 64; model();
        send_rows(4, 1'b1, t0); recv_block("imp", 1'b1);

        for (int n = 0; n < 6; n++) begin
            fill_rand(); model();
            send_rows(4, 1'b1, t0);
            recv_block($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)));
        end

        // Reset after two accepted rows discards the partial block.
        fill_rand();
        send_rows(2, 1'b0, t0);
        reset = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 1);
        chk("midrst d1", d_out_1, 0);
        chk("midrst d2", d_out_2, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fill_const(0); x_blk[0][0] = 64; model();
        send_rows(4, 1'b0, t0); recv_block("postrst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
